// File: rtl/arithmetic_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arithmetic_unit_pkg : ALU opcode encoding and CPU data width.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package arithmetic_unit_pkg;

  localparam int DATA_W   = 19;
  localparam int OPCODE_W = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOT = 5'd0,
    OP_AND = 5'd1,
    OP_OR  = 5'd2,
    OP_XOR = 5'd3,
    OP_ADD = 5'd4,
    OP_SUB = 5'd5,
    OP_MUL = 5'd6,
    OP_DIV = 5'd7,
    OP_INC = 5'd8,
    OP_DEC = 5'd9
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/arithmetic_unit_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arithmetic_unit_divider : unsigned restoring divider, 1 bit per cycle. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module arithmetic_unit_divider
  import arithmetic_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;

  logic [WIDTH:0]   shift_d, diff_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_d, quo_d;

  assign shift_d = {rem_q, quo_q[WIDTH-1]};
  assign diff_d  = shift_d - {1'b0, dvs_q};
  assign fits_d  = ~diff_d[WIDTH];
  assign rem_d   = fits_d ? diff_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], fits_d};

  // The final step's outcome is exposed combinationally so the parent can
  // register it on the same edge that ends the run.
  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arithmetic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arithmetic_unit : ADD/SUB/MUL/DIV/INC/DEC with registered flags.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module arithmetic_unit
  import arithmetic_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OP_W  = OPCODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             div_by_zero,
  output logic             invalid_op
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_DIV_RUN = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             done_q, carry_q, ovf_q, zero_q, neg_q, dbz_q, inv_q;

  logic [WIDTH:0]     add_d, sub_d, inc_d, dec_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   res_d, hi_d;
  logic               carry_d, ovf_d, dbz_d, inv_d, zero_d, neg_d;
  logic               div_go, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign add_d  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_d  = {1'b0, op_a} - {1'b0, op_b};
  assign inc_d  = {1'b0, op_a} + (WIDTH+1)'(1);
  assign dec_d  = {1'b0, op_a} - (WIDTH+1)'(1);
  assign prod_d = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // DIV here only covers the zero-divisor case; real divides take the FSM path.
  always_comb begin
    res_d   = '0;
    hi_d    = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    inv_d   = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        res_d   = add_d[MSB:0];
        carry_d = add_d[WIDTH];
        ovf_d   = (op_a[MSB] == op_b[MSB]) && (add_d[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        res_d   = sub_d[MSB:0];
        carry_d = sub_d[WIDTH];
        ovf_d   = (op_a[MSB] != op_b[MSB]) && (sub_d[MSB] != op_a[MSB]);
      end
      OP_INC: begin
        res_d   = inc_d[MSB:0];
        carry_d = inc_d[WIDTH];
        ovf_d   = ~op_a[MSB] & inc_d[MSB];
      end
      OP_DEC: begin
        res_d   = dec_d[MSB:0];
        carry_d = dec_d[WIDTH];
        ovf_d   = op_a[MSB] & ~dec_d[MSB];
      end
      OP_MUL: begin
        res_d = prod_d[WIDTH-1:0];
        hi_d  = prod_d[2*WIDTH-1:WIDTH];
        ovf_d = |prod_d[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        res_d = '1;
        hi_d  = op_a;
        dbz_d = 1'b1;
      end
      default: inv_d = 1'b1;
    endcase
  end

  assign zero_d = ~inv_d & (res_d == '0);
  assign neg_d  = ~inv_d & res_d[MSB];
  assign div_go = start && (state_q == S_IDLE) && (opcode == OP_DIV) && (op_b != '0);

  arithmetic_unit_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_go),
    .dividend_i  (op_a),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (div_go) begin
            state_q <= S_DIV_RUN;
          end else if (start) begin
            done_q      <= 1'b1;
            result_q    <= res_d;
            result_hi_q <= hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            dbz_q       <= dbz_d;
            inv_q       <= inv_d;
          end
        end
        S_DIV_RUN: begin
          if (div_done) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            result_q    <= div_quo;
            result_hi_q <= div_rem;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (div_quo == '0);
            neg_q       <= div_quo[MSB];
            dbz_q       <= 1'b0;
            inv_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign busy        = div_busy;
  assign done        = done_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;
  assign negative    = neg_q;
  assign div_by_zero = dbz_q;
  assign invalid_op  = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arithmetic_unit : scoreboard bench for arithmetic_unit.            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_arithmetic_unit;
  import arithmetic_unit_pkg::*;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [4:0]   opcode;
  logic [W-1:0] op_a, op_b, result, result_hi;
  logic         busy, done, carry, overflow, zero, negative, div_by_zero, invalid_op;

  arithmetic_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (result),
    .result_hi   (result_hi),
    .busy        (busy),
    .done        (done),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero),
    .negative    (negative),
    .div_by_zero (div_by_zero),
    .invalid_op  (invalid_op)
  );

  always #5 clk = ~clk;

  // flags packed as {carry, overflow, zero, negative, div_by_zero, invalid_op}
  typedef struct {
    string        tag;
    int           cyc;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [5:0]   flg;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [5:0] mon_flg;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && done) begin
      total++;
      mon_flg = {carry, overflow, zero, negative, div_by_zero, invalid_op};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: cyc=%0d res=%h hi=%h flags=%b, required no done", cyc, result, result_hi, mon_flg);
      end else begin
        mon_e = exp_q.pop_front();
        if (result !== mon_e.res || result_hi !== mon_e.hi || mon_flg !== mon_e.flg || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL %s: got res=%h hi=%h flags=%b cyc=%0d, required res=%h hi=%h flags=%b cyc=%0d",
                   mon_e.tag, result, result_hi, mon_flg, cyc, mon_e.res, mon_e.hi, mon_e.flg, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", tag, got, want);
    end
  endtask

  // Drive one request for one cycle; lat==0 means no response is expected.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int lat, input string tag,
                      input logic [W-1:0] er, input logic [W-1:0] eh, input logic [5:0] ef);
    exp_t e;
    start  = 1'b1;
    opcode = op;
    op_a   = a;
    op_b   = b;
    if (lat > 0) begin
      e = '{tag, cyc + lat, er, eh, ef};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; opcode = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {result, result_hi, busy, done, carry, overflow, zero, negative, div_by_zero, invalid_op}, 64'd0);
    rst = 1'b0;
    idle(1);

    send(OP_ADD, 19'h7FFFF, 19'h00001, 1, "add_wrap",   19'h00000, 19'h0, 6'b101000); idle(1);
    send(OP_ADD, 19'h3FFFF, 19'h00001, 1, "add_ovf",    19'h40000, 19'h0, 6'b010100); idle(1);
    send(OP_SUB, 19'd5,     19'd7,     1, "sub_borrow", 19'h7FFFE, 19'h0, 6'b100100); idle(1);
    send(OP_SUB, 19'h3FFFF, 19'h7FFFF, 1, "sub_ovf",    19'h40000, 19'h0, 6'b110100); idle(1);
    send(OP_MUL, 19'h00400, 19'h00400, 1, "mul_hi",     19'h00000, 19'h2, 6'b011000); idle(1);
    send(OP_MUL, 19'h7FFFF, 19'h7FFFF, 1, "mul_max",    19'h00001, 19'h7FFFE, 6'b010000); idle(1);
    send(OP_INC, 19'h7FFFF, 19'h12345, 1, "inc_wrap",   19'h00000, 19'h0, 6'b101000); idle(1);
    send(OP_INC, 19'h3FFFF, 19'h0,     1, "inc_ovf",    19'h40000, 19'h0, 6'b010100); idle(1);
    send(OP_DEC, 19'h00000, 19'h0,     1, "dec_wrap",   19'h7FFFF, 19'h0, 6'b100100); idle(1);
    send(OP_DEC, 19'h40000, 19'h0,     1, "dec_ovf",    19'h3FFFF, 19'h0, 6'b010000); idle(1);
    send(OP_XOR, 19'h00F0F, 19'h0FF00, 1, "xor_invalid", 19'h0,    19'h0, 6'b000001); idle(1);
    send(5'd15,  19'h00001, 19'h00001, 1, "undef_invalid", 19'h0,  19'h0, 6'b000001); idle(1);

    // DIV with an ADD request held during the run, which must be dropped.
    send(OP_DIV, 19'd100, 19'd7, 20, "div_100_7", 19'd14, 19'd2, 6'b000000);
    n = 0;
    while (busy && n < 40) begin
      if (n < 3) begin
        start = 1'b1; opcode = OP_ADD; op_a = 19'd1; op_b = 19'd1;
      end else begin
        start = 1'b0;
      end
      n++;
      @(posedge clk); #1;
    end
    check("div_busy_cycles", 64'(n), 64'd19);
    idle(2);

    send(OP_DIV, 19'h7FFFF, 19'd3, 20, "div_max_3", 19'h2AAAA, 19'd1, 6'b000000);
    idle(22);

    send(OP_DIV, 19'd1234, 19'd0, 1, "div_by_zero", 19'h7FFFF, 19'd1234, 6'b000110);
    check("divzero_no_busy", 64'(busy), 64'd0);
    idle(1);

    send(OP_ADD, 19'd2,  19'd3, 1, "b2b_add", 19'd5, 19'd0, 6'b000000);
    send(OP_SUB, 19'd10, 19'd3, 1, "b2b_sub", 19'd7, 19'd0, 6'b000000);
    send(OP_AND, 19'd1,  19'd1, 1, "b2b_and", 19'd0, 19'd0, 6'b000001);
    idle(3);

    // Reset part-way through a divide: no response may ever appear.
    send(OP_DIV, 19'd500, 19'd3, 0, "div_abort", 19'd0, 19'd0, 6'b0);
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", {result, result_hi, busy, done, carry, overflow, zero, negative, div_by_zero, invalid_op}, 64'd0);
    rst = 1'b0;
    idle(25);

    send(OP_ADD, 19'd1, 19'd1, 1, "after_abort", 19'd2, 19'd0, 6'b000000);
    idle(1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
